// File: rtl/vt100_term_ctrl.sv
// Write-side controller for the 80x24 VT100 screen buffer: consumes a byte stream,
// tracks the cursor, writes glyphs, and performs full-screen and scroll line clears.
module vt100_term_ctrl #(
   parameter int          COLS     = 80,
   parameter int          ROWS     = 24,
   parameter int          ADDR_W   = 11,
   parameter logic [7:0]  CLR_CHAR = 8'h20
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [7:0]        o_wr_data,
   output logic              o_wr,
   output logic [6:0]        o_cur_x,
   output logic [4:0]        o_cur_y,
   output logic [4:0]        o_top_row,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      ST_CLR_ALL  = 2'd0,
      ST_IDLE     = 2'd1,
      ST_CLR_LINE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_CCOL = ADDR_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
   localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [4:0]          clr_row_q, clr_row_d;
   logic [6:0]          cur_x_q, cur_x_d;
   logic [4:0]          cur_y_q, cur_y_d;
   logic [4:0]          top_q, top_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          data_q, data_d;

   logic [6:0]          code;
   logic                unused_bit7;
   logic [5:0]          row_sum;
   logic [4:0]          phys_row;
   logic                do_nl;

   assign code        = i_rx_data[6:0];
   assign unused_bit7 = i_rx_data[7];

   // Logical cursor row mapped onto the circular physical row order.
   assign row_sum  = {1'b0, top_q} + {1'b0, cur_y_q};
   assign phys_row = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];

   assign o_rx_ready = (state_q == ST_IDLE);
   assign o_busy     = ~o_rx_ready;
   assign o_wr       = wr_q;
   assign o_wr_addr  = addr_q;
   assign o_wr_data  = data_q;
   assign o_cur_x    = cur_x_q;
   assign o_cur_y    = cur_y_q;
   assign o_top_row  = top_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_row_d = clr_row_q;
      cur_x_d   = cur_x_q;
      cur_y_d   = cur_y_q;
      top_d     = top_q;
      wr_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      do_nl     = 1'b0;

      case (state_q)
         ST_CLR_ALL: begin
            wr_d   = 1'b1;
            addr_d = cnt_q;
            data_d = CLR_CHAR;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_CELL) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_CLR_LINE: begin
            wr_d   = 1'b1;
            addr_d = ADDR_W'(clr_row_q) * COLS_A + cnt_q;
            data_d = CLR_CHAR;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_CCOL) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (i_rx_valid) begin
               if (code >= 7'h20 && code != 7'h7f) begin
                  wr_d   = 1'b1;
                  addr_d = ADDR_W'(phys_row) * COLS_A + ADDR_W'(cur_x_q);
                  data_d = {1'b0, code};
                  if (cur_x_q == LAST_COL) begin
                     cur_x_d = '0;
                     do_nl   = 1'b1;
                  end else begin
                     cur_x_d = cur_x_q + 7'd1;
                  end
               end else if (code == 7'h0d) begin
                  cur_x_d = '0;
               end else if (code == 7'h08) begin
                  cur_x_d = (cur_x_q == 7'd0) ? 7'd0 : cur_x_q - 7'd1;
               end else if (code == 7'h0a) begin
                  do_nl = 1'b1;
               end
            end
            // Scroll: advance the top row and wipe the row that just became the bottom.
            if (do_nl) begin
               if (cur_y_q != LAST_ROW) begin
                  cur_y_d = cur_y_q + 5'd1;
               end else begin
                  top_d     = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
                  clr_row_d = top_q;
                  cnt_d     = '0;
                  state_d   = ST_CLR_LINE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_CLR_ALL;
         cnt_q     <= '0;
         clr_row_q <= '0;
         cur_x_q   <= '0;
         cur_y_q   <= '0;
         top_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clr_row_q <= clr_row_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
         top_q     <= top_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

endmodule

// File: tb/tb_vt100_term_ctrl.sv
// Directed bench for vt100_term_ctrl: screen clear, printing, control codes,
// auto-wrap scroll, top-row wrap and asynchronous reset during a line clear.
module tb_vt100_term_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        o_rx_ready;
   logic [10:0] o_wr_addr;
   logic [7:0]  o_wr_data;
   logic        o_wr;
   logic [6:0]  o_cur_x;
   logic [4:0]  o_cur_y;
   logic [4:0]  o_top_row;
   logic        o_busy;

   int tests_run = 0;
   int tests_failed = 0;

   vt100_term_ctrl dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rx_data  (i_rx_data),
      .i_rx_valid (i_rx_valid),
      .o_rx_ready (o_rx_ready),
      .o_wr_addr  (o_wr_addr),
      .o_wr_data  (o_wr_data),
      .o_wr       (o_wr),
      .o_cur_x    (o_cur_x),
      .o_cur_y    (o_cur_y),
      .o_top_row  (o_top_row),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   // Returns one cycle after acceptance, i.e. with cycle N+1 outputs visible.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      while (o_rx_ready !== 1'b1 && waited < 3000) begin
         tick();
         waited++;
      end
      if (o_rx_ready !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_wait ready=%b required 1", o_rx_ready);
      end
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      int bad = 0;
      int first_k = -1;
      logic exp_rdy;
      #3;
      tests_run++;
      if (o_wr !== 1'b0 || o_wr_addr !== 11'd0 || o_wr_data !== 8'd0 || o_cur_x !== 7'd0 ||
          o_cur_y !== 5'd0 || o_top_row !== 5'd0 || o_rx_ready !== 1'b0 || o_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_outputs wr=%b addr=%0d data=%h x=%0d y=%0d top=%0d rdy=%b busy=%b required all 0 busy 1",
                  o_wr, o_wr_addr, o_wr_data, o_cur_x, o_cur_y, o_top_row, o_rx_ready, o_busy);
      end
      tick();
      tick();
      i_rst_n = 1'b1;
      for (int k = 0; k < 1920; k++) begin
         tick();
         exp_rdy = (k == 1919);
         if (o_wr !== 1'b1 || o_wr_addr !== 11'(k) || o_wr_data !== 8'h20 || o_rx_ready !== exp_rdy) begin
            if (bad == 0) first_k = k;
            bad++;
         end
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL clr_all_sweep %0d bad cycles, first at k=%0d, required 0 bad", bad, first_k);
      end
      tests_run++;
      if (o_cur_x !== 7'd0 || o_cur_y !== 5'd0 || o_top_row !== 5'd0) begin
         tests_failed++;
         $display("FAIL clr_all_cursor x=%0d y=%0d top=%0d required 0 0 0", o_cur_x, o_cur_y, o_top_row);
      end
      tick();
      tests_run++;
      if (o_wr !== 1'b0 || o_rx_ready !== 1'b1 || o_wr_addr !== 11'd1919) begin
         tests_failed++;
         $display("FAIL idle_after_clr wr=%b rdy=%b addr=%0d required 0 1 1919", o_wr, o_rx_ready, o_wr_addr);
      end
   endtask

   task automatic test_print;
      send_byte(8'h41);
      tests_run++;
      if (o_wr !== 1'b1 || o_wr_addr !== 11'd0 || o_wr_data !== 8'h41 || o_cur_x !== 7'd1) begin
         tests_failed++;
         $display("FAIL print_a wr=%b addr=%0d data=%h x=%0d required 1 0 41 1", o_wr, o_wr_addr, o_wr_data, o_cur_x);
      end
      send_byte(8'h42);
      tests_run++;
      if (o_wr !== 1'b1 || o_wr_addr !== 11'd1 || o_wr_data !== 8'h42 || o_cur_x !== 7'd2) begin
         tests_failed++;
         $display("FAIL print_b wr=%b addr=%0d data=%h x=%0d required 1 1 42 2", o_wr, o_wr_addr, o_wr_data, o_cur_x);
      end
      tick();
      tests_run++;
      if (o_wr !== 1'b0 || o_wr_addr !== 11'd1 || o_wr_data !== 8'h42) begin
         tests_failed++;
         $display("FAIL print_hold wr=%b addr=%0d data=%h required 0 1 42", o_wr, o_wr_addr, o_wr_data);
      end
      send_byte(8'hc3);
      tests_run++;
      if (o_wr !== 1'b1 || o_wr_addr !== 11'd2 || o_wr_data !== 8'h43 || o_cur_x !== 7'd3) begin
         tests_failed++;
         $display("FAIL print_bit7 wr=%b addr=%0d data=%h x=%0d required 1 2 43 3", o_wr, o_wr_addr, o_wr_data, o_cur_x);
      end
   endtask

   task automatic test_ctrl_codes;
      logic [7:0] seq [4];
      logic [6:0] exp_x [4];
      logic [4:0] exp_y [4];
      seq   = '{8'h08, 8'h08, 8'h0d, 8'h0a};
      exp_x = '{7'd4, 7'd3, 7'd0, 7'd0};
      exp_y = '{5'd3, 5'd3, 5'd3, 5'd4};
      send_byte(8'h0d);
      for (int i = 0; i < 3; i++) send_byte(8'h0a);
      for (int i = 0; i < 5; i++) send_byte(8'h2e);
      tests_run++;
      if (o_cur_x !== 7'd5 || o_cur_y !== 5'd3 || o_wr_addr !== 11'd244) begin
         tests_failed++;
         $display("FAIL ctrl_setup x=%0d y=%0d addr=%0d required 5 3 244", o_cur_x, o_cur_y, o_wr_addr);
      end
      for (int i = 0; i < 4; i++) begin
         send_byte(seq[i]);
         tests_run++;
         if (o_wr !== 1'b0 || o_cur_x !== exp_x[i] || o_cur_y !== exp_y[i]) begin
            tests_failed++;
            $display("FAIL ctrl_step%0d wr=%b x=%0d y=%0d required 0 %0d %0d", i, o_wr, o_cur_x, o_cur_y, exp_x[i], exp_y[i]);
         end
      end
      send_byte(8'h08);
      send_byte(8'h07);
      send_byte(8'h7f);
      tests_run++;
      if (o_wr !== 1'b0 || o_cur_x !== 7'd0 || o_cur_y !== 5'd4 || o_rx_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bs_sat_ignored wr=%b x=%0d y=%0d rdy=%b required 0 0 4 1", o_wr, o_cur_x, o_cur_y, o_rx_ready);
      end
   endtask

   task automatic test_wrap_scroll;
      int bad = 0;
      int first_k = -1;
      logic exp_rdy;
      for (int i = 0; i < 19; i++) send_byte(8'h0a);
      for (int i = 0; i < 79; i++) send_byte(8'h2e);
      tests_run++;
      if (o_cur_x !== 7'd79 || o_cur_y !== 5'd23 || o_top_row !== 5'd0) begin
         tests_failed++;
         $display("FAIL wrap_setup x=%0d y=%0d top=%0d required 79 23 0", o_cur_x, o_cur_y, o_top_row);
      end
      send_byte(8'h5a);
      tests_run++;
      if (o_wr !== 1'b1 || o_wr_addr !== 11'd1919 || o_wr_data !== 8'h5a || o_top_row !== 5'd1 ||
          o_cur_x !== 7'd0 || o_cur_y !== 5'd23 || o_rx_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_z wr=%b addr=%0d data=%h top=%0d x=%0d y=%0d rdy=%b required 1 1919 5a 1 0 23 0",
                  o_wr, o_wr_addr, o_wr_data, o_top_row, o_cur_x, o_cur_y, o_rx_ready);
      end
      for (int k = 0; k < 80; k++) begin
         tick();
         exp_rdy = (k == 79);
         if (o_wr !== 1'b1 || o_wr_addr !== 11'(k) || o_wr_data !== 8'h20 || o_rx_ready !== exp_rdy) begin
            if (bad == 0) first_k = k;
            bad++;
         end
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL wrap_clear %0d bad cycles, first at k=%0d, required 0 bad", bad, first_k);
      end
      tick();
      tests_run++;
      if (o_wr !== 1'b0 || o_rx_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_clear_end wr=%b rdy=%b required 0 1", o_wr, o_rx_ready);
      end
   endtask

   task automatic test_top_wrap;
      int bad = 0;
      int first_k = -1;
      logic exp_rdy;
      for (int i = 0; i < 22; i++) send_byte(8'h0a);
      send_byte(8'h00);
      tests_run++;
      if (o_top_row !== 5'd23 || o_cur_x !== 7'd0 || o_cur_y !== 5'd23) begin
         tests_failed++;
         $display("FAIL topwrap_setup top=%0d x=%0d y=%0d required 23 0 23", o_top_row, o_cur_x, o_cur_y);
      end
      send_byte(8'h0a);
      tests_run++;
      if (o_wr !== 1'b0 || o_top_row !== 5'd0 || o_cur_y !== 5'd23 || o_rx_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL topwrap_lf wr=%b top=%0d y=%0d rdy=%b required 0 0 23 0", o_wr, o_top_row, o_cur_y, o_rx_ready);
      end
      for (int k = 0; k < 80; k++) begin
         tick();
         exp_rdy = (k == 79);
         if (o_wr !== 1'b1 || o_wr_addr !== 11'(1840 + k) || o_wr_data !== 8'h20 || o_rx_ready !== exp_rdy) begin
            if (bad == 0) first_k = k;
            bad++;
         end
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL topwrap_clear %0d bad cycles, first at k=%0d, required 0 bad", bad, first_k);
      end
      send_byte(8'h51);
      tests_run++;
      if (o_wr !== 1'b1 || o_wr_addr !== 11'd1840 || o_wr_data !== 8'h51 || o_cur_x !== 7'd1) begin
         tests_failed++;
         $display("FAIL topwrap_q wr=%b addr=%0d data=%h x=%0d required 1 1840 51 1", o_wr, o_wr_addr, o_wr_data, o_cur_x);
      end
   endtask

   task automatic test_reset_mid_clear;
      int bad = 0;
      int first_k = -1;
      logic exp_rdy;
      send_byte(8'h0a);
      for (int i = 0; i < 10; i++) tick();
      i_rst_n = 1'b0;
      #1;
      tests_run++;
      if (o_wr !== 1'b0 || o_wr_addr !== 11'd0 || o_wr_data !== 8'd0 || o_cur_x !== 7'd0 ||
          o_cur_y !== 5'd0 || o_top_row !== 5'd0 || o_rx_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_outputs wr=%b addr=%0d data=%h x=%0d y=%0d top=%0d rdy=%b required all 0",
                  o_wr, o_wr_addr, o_wr_data, o_cur_x, o_cur_y, o_top_row, o_rx_ready);
      end
      i_rx_data  = 8'h4b;
      i_rx_valid = 1'b1;
      tick();
      tick();
      i_rst_n = 1'b1;
      for (int k = 0; k < 1920; k++) begin
         tick();
         exp_rdy = (k == 1919);
         if (o_wr !== 1'b1 || o_wr_addr !== 11'(k) || o_wr_data !== 8'h20 || o_rx_ready !== exp_rdy) begin
            if (bad == 0) first_k = k;
            bad++;
         end
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL midreset_sweep %0d bad cycles, first at k=%0d, required 0 bad", bad, first_k);
      end
      tick();
      i_rx_valid = 1'b0;
      tests_run++;
      if (o_wr !== 1'b1 || o_wr_addr !== 11'd0 || o_wr_data !== 8'h4b || o_cur_x !== 7'd1) begin
         tests_failed++;
         $display("FAIL held_byte wr=%b addr=%0d data=%h x=%0d required 1 0 4b 1", o_wr, o_wr_addr, o_wr_data, o_cur_x);
      end
      tick();
      tests_run++;
      if (o_wr !== 1'b0 || o_cur_x !== 7'd1) begin
         tests_failed++;
         $display("FAIL held_once wr=%b x=%0d required 0 1", o_wr, o_cur_x);
      end
   endtask

   initial begin
      test_reset();
      test_print();
      test_ctrl_codes();
      test_wrap_scroll();
      test_top_wrap();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
